// File: rtl/line_raster.sv
// rtl/line_raster.sv - eight-octant Bresenham line rasteriser with a stallable pixel stream
module line_raster #(
    parameter int COORD_W = 10,
    parameter int COLOR_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic [COORD_W-1:0] x0,
    input  logic [COORD_W-1:0] y0,
    input  logic [COORD_W-1:0] x1,
    input  logic [COORD_W-1:0] y1,
    input  logic [COLOR_W-1:0] color,
    output logic               busy,
    output logic               done,
    output logic               pix_valid,
    input  logic               pix_ready,
    output logic [COORD_W-1:0] pix_x,
    output logic [COORD_W-1:0] pix_y,
    output logic [COLOR_W-1:0] pix_color
);

    localparam int DW = COORD_W + 2;
    localparam int EW = COORD_W + 3;
    localparam logic [COORD_W-1:0] ONE = {{(COORD_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        DRAW
    } state_t;

    state_t state;
    state_t state_next;

    logic [COORD_W-1:0] start_x;
    logic [COORD_W-1:0] start_y;
    logic [COORD_W-1:0] end_x;
    logic [COORD_W-1:0] end_y;

    logic signed [DW-1:0] dx;
    logic signed [DW-1:0] dy;
    logic signed [DW-1:0] err;
    logic                 step_x_neg;
    logic                 step_y_neg;

    logic signed [DW-1:0] diff_x;
    logic signed [DW-1:0] diff_y;
    logic signed [DW-1:0] abs_x;
    logic signed [DW-1:0] abs_y;
    logic signed [EW-1:0] e2;
    logic signed [EW-1:0] dx_ext;
    logic signed [EW-1:0] dy_ext;
    logic signed [DW-1:0] err_next;
    logic                 move_x;
    logic                 move_y;
    logic                 handshake;
    logic                 at_end;
    logic                 done_next;

    assign diff_x = $signed({2'b00, end_x}) - $signed({2'b00, start_x});
    assign diff_y = $signed({2'b00, end_y}) - $signed({2'b00, start_y});
    assign abs_x  = diff_x[DW-1] ? -diff_x : diff_x;
    assign abs_y  = diff_y[DW-1] ? -diff_y : diff_y;

    // Both step decisions use the error term from before this beat's update.
    assign e2       = $signed({err, 1'b0});
    assign dx_ext   = $signed({dx[DW-1], dx});
    assign dy_ext   = $signed({dy[DW-1], dy});
    assign move_x   = (e2 >= dy_ext);
    assign move_y   = (e2 <= dx_ext);
    assign err_next = err + (move_x ? dy : '0) + (move_y ? dx : '0);

    assign handshake = (state == DRAW) && pix_ready;
    assign at_end    = (pix_x == end_x) && (pix_y == end_y);
    assign busy      = (state != IDLE);
    assign pix_valid = (state == DRAW);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            done  <= done_next;
        end
    end

    always_comb begin
        state_next = state;
        done_next  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = SETUP;
                end
            end
            SETUP: begin
                state_next = abort ? IDLE : DRAW;
            end
            DRAW: begin
                // Abort wins the state even when the beat itself was accepted.
                if (abort) begin
                    state_next = IDLE;
                end else if (handshake && at_end) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            start_x    <= '0;
            start_y    <= '0;
            end_x      <= '0;
            end_y      <= '0;
            pix_color  <= '0;
            pix_x      <= '0;
            pix_y      <= '0;
            dx         <= '0;
            dy         <= '0;
            err        <= '0;
            step_x_neg <= 1'b0;
            step_y_neg <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        start_x   <= x0;
                        start_y   <= y0;
                        end_x     <= x1;
                        end_y     <= y1;
                        pix_color <= color;
                    end
                end
                SETUP: begin
                    dx         <= abs_x;
                    dy         <= -abs_y;
                    err        <= abs_x - abs_y;
                    step_x_neg <= diff_x[DW-1];
                    step_y_neg <= diff_y[DW-1];
                    pix_x      <= start_x;
                    pix_y      <= start_y;
                end
                DRAW: begin
                    // The walk stays inside the endpoint bounding box, so steps never wrap.
                    if (handshake && !at_end) begin
                        err <= err_next;
                        if (move_x) begin
                            pix_x <= step_x_neg ? pix_x - ONE : pix_x + ONE;
                        end
                        if (move_y) begin
                            pix_y <= step_y_neg ? pix_y - ONE : pix_y + ONE;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
